// File: rtl/booth_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : booth_pkg
//  Purpose : Shared constants and types for the radix-2 Booth multiplier
//            controller: state encoding, widths and Booth select codes.
//  Rev     : 1.0  initial release
// ============================================================================
package booth_pkg;

    localparam int BOOTH_W = 32;
    localparam int PROD_W  = 2 * BOOTH_W + 1;

    // State encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_EXEC = EXEC,
        ST_DONE = DONE
    } state_t;

    // Booth select codes
    typedef enum logic [1:0] {
        SEL_NOP = 2'd0,
        SEL_ADD = 2'd1,
        SEL_SUB = 2'd2
    } sel_t;

    // Decode the current Booth pair {Q0, Q-1} into an add/sub/nop selection.
    function automatic sel_t booth_sel(input logic [1:0] pair);
        case (pair)
            2'b01:   return SEL_ADD;
            2'b10:   return SEL_SUB;
            default: return SEL_NOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : booth_mult_ctrl_if
//  Purpose : Start/busy/done handshake and operand/result bus of the Booth
//            multiplier.
//  Ports   : start, mcand, mplier  (requester -> multiplier)
//            busy, done, product, err (multiplier -> requester)
//  Rev     : 1.0  initial release
// ============================================================================
interface booth_mult_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic                   start;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   err;

    modport master (
        output start, mcand, mplier,
        input  busy, done, product, err
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product, err
    );
endinterface
`default_nettype wire

// File: rtl/booth_step_addsub.sv
`default_nettype none
// ============================================================================
//  Module  : booth_step_addsub
//  Purpose : Combinational Booth add/sub stage: A' = A + M, A - M or A,
//            selected by the pair {Q0, Q-1}. Wraps modulo 2^WIDTH.
//  Ports   : pair   in  2      {Q0, Q-1}
//            a      in  WIDTH  accumulator A
//            m      in  WIDTH  multiplicand M
//            a_next out WIDTH  updated accumulator A'
//  Rev     : 1.0  initial release
// ============================================================================
module booth_step_addsub
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_W
) (
    input  logic [1:0]       pair,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next
);

    always_comb begin
        a_next = a;
        case (booth_sel(pair))
            SEL_ADD: a_next = a + m;
            SEL_SUB: a_next = a - m;
            default: a_next = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : booth_mult_ctrl
//  Purpose : Sequential radix-2 Booth multiplier controller. Drives an
//            external (2*WIDTH+1)-bit arithmetic-shift product register that
//            captures on the negedge, and retires one Booth bit per clock.
//  Ports   : clk, rst            clock, synchronous active-high reset
//            bus (slave)         start/mcand/mplier -> busy/done/product/err
//            prod_q              product register output {A, Q, Q-1}
//            prod_d              product register input (combinational)
//            prod_en             product register enable
//            prod_shift          1: register stores prod_d >>> 1
//  Rev     : 1.0  initial release
// ============================================================================
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_W
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_mult_ctrl_if.slave     bus,
    input  logic [2*WIDTH:0]     prod_q,
    output logic [2*WIDTH:0]     prod_d,
    output logic                 prod_en,
    output logic                 prod_shift
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] M_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 last_step;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [WIDTH-1:0]     a_cur;
    logic [WIDTH-1:0]     a_nxt;
    logic [2*WIDTH-1:0]   product_reg;
    logic                 err_reg;

    assign a_cur     = prod_q[2*WIDTH:WIDTH+1];
    assign last_step = (state == ST_EXEC) && (cnt == CNT_LAST);

    booth_step_addsub #(
        .WIDTH  (WIDTH)
    ) u_step (
        .pair   (prod_q[1:0]),
        .a      (a_cur),
        .m      (m_reg),
        .a_next (a_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            m_reg       <= '0;
            mplier_reg  <= '0;
            product_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                m_reg      <= bus.mcand;
                mplier_reg <= bus.mplier;
            end
            if (state == ST_LOAD) begin
                cnt <= '0;
            end else if (state == ST_EXEC) begin
                cnt <= cnt + 1'b1;
            end
            // The final shift landed on the preceding negedge, so prod_q
            // already holds the finished product as DONE is entered.
            if (last_step) begin
                product_reg <= prod_q[2*WIDTH:1];
                err_reg     <= (m_reg == M_MIN);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        prod_d     = '0;
        prod_en    = 1'b0;
        prod_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                prod_d    = {{WIDTH{1'b0}}, mplier_reg, 1'b0};
                prod_en   = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                prod_d     = {a_nxt, prod_q[WIDTH:0]};
                prod_en    = 1'b1;
                prod_shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset silences the register drive in the very cycle it is asserted.
        if (rst) begin
            state_nxt  = ST_IDLE;
            accept     = 1'b0;
            prod_d     = '0;
            prod_en    = 1'b0;
            prod_shift = 1'b0;
        end
    end

    assign bus.busy    = !rst && ((state == ST_LOAD) || (state == ST_EXEC));
    assign bus.done    = !rst && (state == ST_DONE);
    assign bus.product = product_reg;
    assign bus.err     = err_reg;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_booth_mult_ctrl
//  Purpose : Directed self-checking bench for booth_mult_ctrl together with a
//            negedge-capturing arithmetic-shift product register.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_booth_mult_ctrl;
    import booth_pkg::*;

    localparam int W = BOOTH_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*W:0]    prod_q;
    logic [2*W:0]    prod_d;
    logic            prod_en;
    logic            prod_shift;
    logic [2*W:0]    preg = '0;

    int vecs = 0;
    int errs = 0;

    booth_mult_ctrl_if #(.WIDTH(W)) bus ();

    booth_mult_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .prod_q     (prod_q),
        .prod_d     (prod_d),
        .prod_en    (prod_en),
        .prod_shift (prod_shift)
    );

    always #5 clk = ~clk;

    // Product register: captures on the negedge, optional arithmetic shift.
    always @(negedge clk) begin
        if (prod_en) begin
            preg <= prod_shift ? {prod_d[2*W], prod_d[2*W:1]} : prod_d;
        end
    end
    assign prod_q = preg;

    // Pulse start for one accepting edge; returns in cycle 1 (LOAD).
    task automatic launch(input logic [W-1:0] mc, input logic [W-1:0] mp);
        bus.mcand  = mc;
        bus.mplier = mp;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    // Advance until done (bounded); cyc is the cycle number of done.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        vecs++; if (bus.product !== 64'd0) begin errs++; $display("FAIL reset_product got=%h exp=0", bus.product); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        vecs++; if ({prod_en, prod_shift} !== 2'b00) begin errs++; $display("FAIL reset_prod_ctl got=%b exp=00", {prod_en, prod_shift}); end
        vecs++; if (prod_d !== 65'd0) begin errs++; $display("FAIL reset_prod_d got=%h exp=0", prod_d); end
    endtask

    task automatic test_basic();
        int cyc, bn;
        launch(32'd3, 32'd5);
        wait_done(cyc, bn);
        vecs++; if (cyc !== 34) begin errs++; $display("FAIL basic_latency got=%0d exp=34", cyc); end
        vecs++; if (bn !== 33) begin errs++; $display("FAIL basic_busy_cycles got=%0d exp=33", bn); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL basic_busy_in_done got=%b exp=0", bus.busy); end
        vecs++; if (bus.product !== 64'd15) begin errs++; $display("FAIL basic_product got=%h exp=%h", bus.product, 64'd15); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL basic_err got=%b exp=0", bus.err); end
        vecs++; if (prod_en !== 1'b0) begin errs++; $display("FAIL basic_en_in_done got=%b exp=0", prod_en); end
        @(posedge clk); #1;
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
        vecs++; if (bus.product !== 64'd15) begin errs++; $display("FAIL basic_product_hold got=%h exp=%h", bus.product, 64'd15); end
    endtask

    task automatic test_signed();
        int cyc, bn;
        launch(32'hFFFF_FFF9, 32'd6);
        wait_done(cyc, bn);
        vecs++; if (bus.product !== 64'hFFFF_FFFF_FFFF_FFD6) begin errs++; $display("FAIL signed_m7x6 got=%h exp=ffffffffffffffd6", bus.product); end
        @(posedge clk); #1;
        launch(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        wait_done(cyc, bn);
        vecs++; if (bus.product !== 64'd64) begin errs++; $display("FAIL signed_m8xm8 got=%h exp=%h", bus.product, 64'd64); end
        vecs++; if (cyc !== 34) begin errs++; $display("FAIL signed_latency got=%0d exp=34", cyc); end
    endtask

    task automatic test_extremes();
        int cyc, bn;
        @(posedge clk); #1;
        launch(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_done(cyc, bn);
        vecs++; if (bus.product !== 64'h3FFF_FFFF_0000_0001) begin errs++; $display("FAIL ext_maxpos got=%h exp=3fffffff00000001", bus.product); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL ext_maxpos_err got=%b exp=0", bus.err); end
        @(posedge clk); #1;
        launch(32'h8000_0000, 32'd1);
        wait_done(cyc, bn);
        vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL ext_minneg_done got=%b exp=1", bus.done); end
        vecs++; if (bus.err !== 1'b1) begin errs++; $display("FAIL ext_minneg_err got=%b exp=1", bus.err); end
        @(posedge clk); #1;
        launch(32'd0, 32'h1234_5678);
        wait_done(cyc, bn);
        vecs++; if (cyc !== 34) begin errs++; $display("FAIL ext_zero_latency got=%0d exp=34", cyc); end
        vecs++; if (bus.product !== 64'd0) begin errs++; $display("FAIL ext_zero_product got=%h exp=0", bus.product); end
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL ext_zero_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_restart_ignored();
        int cyc;
        @(posedge clk); #1;
        launch(32'd11, 32'd13);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (cyc == 5 || cyc == 20) begin
                bus.start  = 1'b1;
                bus.mcand  = 32'd100;
                bus.mplier = 32'd200;
            end else begin
                bus.start  = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        vecs++; if (cyc !== 34) begin errs++; $display("FAIL restart_latency got=%0d exp=34", cyc); end
        vecs++; if (bus.product !== 64'd143) begin errs++; $display("FAIL restart_product got=%h exp=%h", bus.product, 64'd143); end
    endtask

    task automatic test_reset_mid();
        int cyc, bn, dn;
        @(posedge clk); #1;
        launch(32'd9, 32'd9);
        for (int i = 1; i < 12; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        vecs++; if (prod_en !== 1'b0) begin errs++; $display("FAIL rstmid_en_same_cycle got=%b exp=0", prod_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        vecs++; if (bus.product !== 64'd0) begin errs++; $display("FAIL rstmid_product got=%h exp=0", bus.product); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
            @(posedge clk); #1;
        end
        vecs++; if (dn !== 0) begin errs++; $display("FAIL rstmid_activity got=%0d exp=0", dn); end
        launch(32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bn);
        vecs++; if (bus.product !== 64'hFFFF_FFFF_FFFF_FFEB) begin errs++; $display("FAIL rstmid_after got=%h exp=ffffffffffffffeb", bus.product); end
    endtask

    task automatic test_back_to_back();
        int cyc, bn;
        @(posedge clk); #1;
        bus.mcand  = 32'd6;
        bus.mplier = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        // Operands already captured; these are what the DONE-cycle start sees.
        bus.mcand  = 32'hFFFF_FFFB;
        bus.mplier = 32'hFFFF_FFF7;
        wait_done(cyc, bn);
        vecs++; if (cyc !== 34) begin errs++; $display("FAIL b2b_first_latency got=%0d exp=34", cyc); end
        vecs++; if (bus.product !== 64'd42) begin errs++; $display("FAIL b2b_first_product got=%h exp=%h", bus.product, 64'd42); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc, bn);
        vecs++; if (cyc !== 34) begin errs++; $display("FAIL b2b_second_spacing got=%0d exp=34", cyc); end
        vecs++; if (bus.product !== 64'd45) begin errs++; $display("FAIL b2b_second_product got=%h exp=%h", bus.product, 64'd45); end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.mcand  = '0;
        bus.mplier = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic();
        test_signed();
        test_extremes();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
